rr_arbiter8: RTL and testbench

Round-robin arbiter granting one of eight requesters exclusive use of a shared resource. Each cycle it encodes the pending request vector against a rotating priority pointer and produces a registered one-hot grant plus its 3-bit index, so the index bus drives the shared resource's select directly. Grants are held until the owner drops its request. An optional hold limit preempts an owner that starves other requesters. The block sits between the eight request sources and the shared datapath mux/encoder.

---
 rtl/rr_arbiter8.sv | 116 +++++++++++
 tb/tb_rr_arbiter8.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant, binary index,
// and an optional hold limit that preempts an owner starving other requesters.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_req,
  output logic [7:0] o_grant,
  output logic [2:0] o_grant_idx,
  output logic       o_grant_valid,
  output logic       o_preempt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam bit         PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST  = (MAX_HOLD > 0) ? 8'(MAX_HOLD - 1) : 8'd0;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_ptr, w_ptr_nxt;
  logic [7:0] r_hold_cnt, w_hold_nxt;
  logic [7:0] r_grant, w_grant_nxt;
  logic [2:0] r_grant_idx, w_idx_nxt;
  logic       r_grant_valid, w_valid_nxt;
  logic       r_preempt, w_preempt_nxt;

  logic [7:0] w_rot;
  logic [2:0] w_off;
  logic [2:0] w_sel;
  logic       w_owner_req;
  logic       w_others;
  logic       w_at_limit;

  // Rotate so bit 0 is the highest-priority index, then take the lowest set bit.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < 8; i++) begin
      w_rot[i] = i_req[r_ptr + 3'(i)];
    end
    w_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_rot[i]) w_off = 3'(i);
    end
  end

  assign w_sel       = r_ptr + w_off;
  assign w_owner_req = i_req[r_grant_idx];
  assign w_others    = |(i_req & ~r_grant);
  assign w_at_limit  = (r_hold_cnt == HOLD_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    w_grant_nxt   = r_grant;
    w_idx_nxt     = r_grant_idx;
    w_valid_nxt   = r_grant_valid;
    w_preempt_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (|i_req) begin
          w_grant_nxt = 8'b1 << w_sel;
          w_idx_nxt   = w_sel;
          w_valid_nxt = 1'b1;
          w_hold_nxt  = 8'd0;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        // Both release paths leave the index untouched so it keeps its last value.
        if (!w_owner_req) begin
          w_grant_nxt = 8'd0;
          w_valid_nxt = 1'b0;
          w_ptr_nxt   = r_grant_idx + 3'd1;
          w_state_nxt = IDLE;
        end else if (PREEMPT_EN && w_at_limit && w_others) begin
          w_grant_nxt   = 8'd0;
          w_valid_nxt   = 1'b0;
          w_preempt_nxt = 1'b1;
          w_ptr_nxt     = r_grant_idx + 3'd1;
          w_state_nxt   = IDLE;
        end else if (PREEMPT_EN && !w_at_limit) begin
          w_hold_nxt = r_hold_cnt + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_ptr         <= 3'd0;
      r_hold_cnt    <= 8'd0;
      r_grant       <= 8'd0;
      r_grant_idx   <= 3'd0;
      r_grant_valid <= 1'b0;
      r_preempt     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_hold_cnt    <= w_hold_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_idx   <= w_idx_nxt;
      r_grant_valid <= w_valid_nxt;
      r_preempt     <= w_preempt_nxt;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_idx   = r_grant_idx;
  assign o_grant_valid = r_grant_valid;
  assign o_preempt     = r_preempt;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 (MAX_HOLD=4); each check compares the packed
// tuple {grant, grant_idx, grant_valid, preempt} against a hand-computed value.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [7:0] req = 8'd0;
  logic [7:0] grant;
  logic [2:0] grantIdx;
  logic       grantValid;
  logic       preempt;

  int checkCount = 0;
  int errorCount = 0;

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_req         (req),
    .o_grant       (grant),
    .o_grant_idx   (grantIdx),
    .o_grant_valid (grantValid),
    .o_preempt     (preempt)
  );

  always #5 clk = ~clk;

  // Observed/expected are packed as {grant[7:0], idx[2:0], valid, preempt}.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed={grant,idx,valid,preempt}=0x%0h required=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] reqValue);
    req = reqValue;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rstN = 1'b0;
    #2;
    rstN = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] g;
    logic [7:0] oneHot;

    // Reset and single request
    rstN = 1'b0;
    req  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", {grant, grantIdx, grantValid, preempt}, {8'h00, 3'd0, 1'b0, 1'b0});
    rstN = 1'b1;
    applyStimulus(8'h04);
    checkOutput("single_grant", {grant, grantIdx, grantValid, preempt}, {8'h04, 3'd2, 1'b1, 1'b0});
    applyStimulus(8'h00);
    checkOutput("single_release", {grant, grantIdx, grantValid, preempt}, {8'h00, 3'd2, 1'b0, 1'b0});
    applyStimulus(8'h09);
    checkOutput("ptr_after_release", {grant, grantIdx, grantValid, preempt}, {8'h08, 3'd3, 1'b1, 1'b0});
    applyStimulus(8'h00);
    checkOutput("ptr_release2", {grant, grantIdx, grantValid, preempt}, {8'h00, 3'd3, 1'b0, 1'b0});

    // Round-robin fairness under full contention
    applyReset();
    for (int e = 0; e < 9; e++) begin
      g      = 3'(e % 8);
      oneHot = 8'b1 << g;
      applyStimulus(8'hFF);
      checkOutput("rr_grant", {grant, grantIdx, grantValid, preempt}, {oneHot, g, 1'b1, 1'b0});
      applyStimulus(8'hFF);
      checkOutput("rr_hold", {grant, grantIdx, grantValid, preempt}, {oneHot, g, 1'b1, 1'b0});
      applyStimulus(8'hFF & ~oneHot);
      checkOutput("rr_gap", {grant, grantIdx, grantValid, preempt}, {8'h00, g, 1'b0, 1'b0});
    end

    // Pointer wrap
    applyReset();
    applyStimulus(8'h40);
    checkOutput("wrap_grant6", {grant, grantIdx, grantValid, preempt}, {8'h40, 3'd6, 1'b1, 1'b0});
    applyStimulus(8'h00);
    applyStimulus(8'h81);
    checkOutput("wrap_grant7", {grant, grantIdx, grantValid, preempt}, {8'h80, 3'd7, 1'b1, 1'b0});
    applyStimulus(8'h00);
    checkOutput("wrap_release7", {grant, grantIdx, grantValid, preempt}, {8'h00, 3'd7, 1'b0, 1'b0});
    applyStimulus(8'h81);
    checkOutput("wrap_grant0", {grant, grantIdx, grantValid, preempt}, {8'h01, 3'd0, 1'b1, 1'b0});
    applyStimulus(8'h00);

    // Preemption after exactly four held cycles
    applyReset();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(8'h22);
      checkOutput("preempt_hold", {grant, grantIdx, grantValid, preempt}, {8'h02, 3'd1, 1'b1, 1'b0});
    end
    applyStimulus(8'h22);
    checkOutput("preempt_pulse", {grant, grantIdx, grantValid, preempt}, {8'h00, 3'd1, 1'b0, 1'b1});
    applyStimulus(8'h22);
    checkOutput("preempt_next", {grant, grantIdx, grantValid, preempt}, {8'h20, 3'd5, 1'b1, 1'b0});
    applyStimulus(8'h00);
    checkOutput("preempt_release", {grant, grantIdx, grantValid, preempt}, {8'h00, 3'd5, 1'b0, 1'b0});

    // Single requester keeps the grant past the hold limit
    applyReset();
    for (int c = 0; c < 40; c++) begin
      applyStimulus(8'h08);
      checkOutput("no_contention", {grant, grantIdx, grantValid, preempt}, {8'h08, 3'd3, 1'b1, 1'b0});
    end
    applyStimulus(8'h00);

    // Asynchronous reset in the middle of a grant, with ptr=1 beforehand
    applyReset();
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h10);
    checkOutput("midreset_grant", {grant, grantIdx, grantValid, preempt}, {8'h10, 3'd4, 1'b1, 1'b0});
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midreset_async", {grant, grantIdx, grantValid, preempt}, {8'h00, 3'd0, 1'b0, 1'b0});
    #2;
    rstN = 1'b1;
    applyStimulus(8'h11);
    checkOutput("midreset_ptr0", {grant, grantIdx, grantValid, preempt}, {8'h01, 3'd0, 1'b1, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
